// File: rtl/lsf_input_sequencer.sv
// rtl/lsf_input_sequencer.sv - LSF write-side front end: one SLC candidate plus its hits into the roi/mdt_hit FIFOs
module lsf_input_sequencer #(
    parameter int HIT_BUF_DEPTH = 16,
    parameter int MAX_HITS      = 1023,
    parameter int CNT_W         = 16,
    parameter int HEG2SFSLC_LEN = 64,
    parameter int HEG2SFHIT_LEN = 48
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [HEG2SFSLC_LEN-1:0] slc_in,
    input  logic                     slc_in_dv,
    input  logic [HEG2SFHIT_LEN-1:0] hit_in,
    input  logic                     hit_in_dv,
    input  logic                     hit_in_last,
    output logic [HEG2SFSLC_LEN-1:0] roi,
    output logic                     roi_we,
    input  logic                     roi_af,
    output logic [HEG2SFHIT_LEN-1:0] mdt_hit,
    output logic                     mdt_hit_we,
    input  logic                     mdt_hit_af,
    output logic [9:0]               hit_count,
    output logic                     hit_count_vld,
    output logic                     busy,
    output logic [CNT_W-1:0]         slc_drop_cnt,
    output logic [CNT_W-1:0]         hit_drop_cnt
);

    localparam int             AW      = $clog2(HIT_BUF_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(HIT_BUF_DEPTH);
    localparam logic [9:0]     MAX_C   = 10'(MAX_HITS);
    localparam logic [CNT_W-1:0] SAT   = '1;

    typedef enum logic [2:0] {IDLE, ROI, HITS, DRAIN, DONE} state_t;

    state_t                   state;
    logic [HEG2SFHIT_LEN-1:0] mem [HIT_BUF_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic [9:0]               acc_cnt;
    logic [9:0]               fwd_cnt;
    logic                     last_seen;

    logic slc_ok;
    logic window;
    logic pop;
    logic push;
    logic hit_drop;
    logic slc_drop;

    // Hits travelling with the accepted SLC pulse already belong to the new candidate.
    always_comb begin
        slc_ok   = slc_in_dv && !roi_af && (state == IDLE);
        window   = slc_ok || (state == ROI) || (state == HITS);
        pop      = ((state == ROI) || (state == HITS) || (state == DRAIN)) &&
                   (count != '0) && !mdt_hit_af;
        push     = window && hit_in_dv && ((count != DEPTH_C) || pop) && (acc_cnt != MAX_C);
        hit_drop = hit_in_dv && !push;
        slc_drop = slc_in_dv && !slc_ok;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= hit_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            roi           <= '0;
            roi_we        <= 1'b0;
            mdt_hit       <= '0;
            mdt_hit_we    <= 1'b0;
            hit_count     <= '0;
            hit_count_vld <= 1'b0;
            busy          <= 1'b0;
            slc_drop_cnt  <= '0;
            hit_drop_cnt  <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            acc_cnt       <= '0;
            fwd_cnt       <= '0;
            last_seen     <= 1'b0;
        end else begin
            roi_we        <= 1'b0;
            hit_count_vld <= 1'b0;
            mdt_hit_we    <= pop;

            if (pop) begin
                mdt_hit <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
                fwd_cnt <= fwd_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (slc_drop && (slc_drop_cnt != SAT)) begin
                slc_drop_cnt <= slc_drop_cnt + 1'b1;
            end
            if (hit_drop && (hit_drop_cnt != SAT)) begin
                hit_drop_cnt <= hit_drop_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    acc_cnt <= {9'b0, push};
                    fwd_cnt <= '0;
                    if (slc_ok) begin
                        roi       <= slc_in;
                        roi_we    <= 1'b1;
                        busy      <= 1'b1;
                        last_seen <= hit_in_last;
                        state     <= ROI;
                    end
                end
                ROI: begin
                    state <= (last_seen || hit_in_last) ? DRAIN : HITS;
                end
                HITS: begin
                    if (hit_in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An empty buffer here means the final pop's write is on the bus this cycle.
                    if (count == '0) begin
                        hit_count     <= fwd_cnt;
                        hit_count_vld <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    last_seen <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsf_input_sequencer.sv
// tb/tb_lsf_input_sequencer.sv - directed self-checking bench for lsf_input_sequencer
module tb_lsf_input_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] slc_in = '0;
    logic        slc_in_dv = 1'b0;
    logic [47:0] hit_in = '0;
    logic        hit_in_dv = 1'b0;
    logic        hit_in_last = 1'b0;
    logic [63:0] roi;
    logic        roi_we;
    logic        roi_af = 1'b0;
    logic [47:0] mdt_hit;
    logic        mdt_hit_we;
    logic        mdt_hit_af = 1'b0;
    logic [9:0]  hit_count;
    logic        hit_count_vld;
    logic        busy;
    logic [15:0] slc_drop_cnt;
    logic [15:0] hit_drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [47:0] wq[$];
    int          roi_n = 0;
    int          vld_n = 0;
    int          early_n = 0;
    logic        roi_open = 1'b0;

    lsf_input_sequencer #(
        .HIT_BUF_DEPTH(16), .MAX_HITS(1023), .CNT_W(16),
        .HEG2SFSLC_LEN(64), .HEG2SFHIT_LEN(48)
    ) dut (
        .clock(clock), .reset(reset),
        .slc_in(slc_in), .slc_in_dv(slc_in_dv),
        .hit_in(hit_in), .hit_in_dv(hit_in_dv), .hit_in_last(hit_in_last),
        .roi(roi), .roi_we(roi_we), .roi_af(roi_af),
        .mdt_hit(mdt_hit), .mdt_hit_we(mdt_hit_we), .mdt_hit_af(mdt_hit_af),
        .hit_count(hit_count), .hit_count_vld(hit_count_vld), .busy(busy),
        .slc_drop_cnt(slc_drop_cnt), .hit_drop_cnt(hit_drop_cnt)
    );

    always #5 clock = ~clock;

    // FIFO-side observer; a hit write with no open candidate is an ordering violation.
    always @(negedge clock) begin
        if (reset) begin
            roi_open = 1'b0;
        end else begin
            if (roi_we) begin
                roi_n++;
                roi_open = 1'b1;
            end
            if (mdt_hit_we) begin
                wq.push_back(mdt_hit);
                if (!roi_open) early_n++;
            end
            if (hit_count_vld) begin
                vld_n++;
                roi_open = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_slc(input logic [63:0] d);
        slc_in = d;
        slc_in_dv = 1'b1;
        tick();
        slc_in_dv = 1'b0;
    endtask

    task automatic send_hit(input logic [47:0] d, input logic last);
        hit_in = d;
        hit_in_dv = 1'b1;
        hit_in_last = last;
        tick();
        hit_in_dv = 1'b0;
        hit_in_last = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (hit_count_vld) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {63'b0, ok}, 64'd1);
    endtask

    function automatic logic [47:0] hv(input int t, input int i);
        return 48'hA0_0000_0000 | (48'(t) << 16) | 48'(i);
    endfunction

    task automatic chk_writes(input string tag, input int base, input int t, input int n);
        chk(tag, 64'(wq.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < wq.size()) chk(tag, 64'(wq[base + i]), 64'(hv(t, i + 1)));
        end
    endtask

    initial begin
        int base;
        int r0;
        int v0;

        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_roi_we", 64'(roi_we), 64'd0);
        chk("rst_mdt_we", 64'(mdt_hit_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hcnt", 64'(hit_count), 64'd0);
        chk("rst_sdrop", 64'(slc_drop_cnt), 64'd0);
        chk("rst_hdrop", 64'(hit_drop_cnt), 64'd0);

        // 1: five hits, roi one cycle after the pulse
        base = wq.size(); r0 = roi_n; v0 = vld_n;
        send_slc(64'h1111_2222_3333_4444);
        chk("t1_roi_we", 64'(roi_we), 64'd1);
        chk("t1_roi", roi, 64'h1111_2222_3333_4444);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 5; i++) send_hit(hv(1, i), i == 5);
        wait_vld("t1_vld_seen");
        chk("t1_hcnt", 64'(hit_count), 64'd5);
        tick(); tick();
        chk("t1_vld_once", 64'(vld_n - v0), 64'd1);
        chk("t1_roi_once", 64'(roi_n - r0), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk_writes("t1_wr", base, 1, 5);

        // 2: roi_af refuses the candidate, following hits are orphans
        r0 = roi_n;
        roi_af = 1'b1;
        send_slc(64'h2);
        roi_af = 1'b0;
        chk("t2_roi_we", 64'(roi_we), 64'd0);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_sdrop", 64'(slc_drop_cnt), 64'd1);
        for (int i = 1; i <= 3; i++) send_hit(hv(2, i), i == 3);
        tick();
        chk("t2_hdrop", 64'(hit_drop_cnt), 64'd3);
        chk("t2_no_roi", 64'(roi_n - r0), 64'd0);

        // 3: 20 hits against a blocked mdt_hit FIFO
        base = wq.size();
        mdt_hit_af = 1'b1;
        send_slc(64'h3);
        for (int i = 1; i <= 20; i++) send_hit(hv(3, i), i == 20);
        tick(); tick();
        chk("t3_hdrop", 64'(hit_drop_cnt), 64'd7);
        chk("t3_held", 64'(wq.size() - base), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        mdt_hit_af = 1'b0;
        wait_vld("t3_vld_seen");
        chk("t3_hcnt", 64'(hit_count), 64'd16);
        chk_writes("t3_wr", base, 3, 16);

        // 4: second SLC while collecting hits is dropped
        tick();
        base = wq.size(); r0 = roi_n;
        send_slc(64'h4);
        send_hit(hv(4, 1), 1'b0);
        send_hit(hv(4, 2), 1'b0);
        send_slc(64'h44);
        send_hit(hv(4, 3), 1'b1);
        wait_vld("t4_vld_seen");
        chk("t4_hcnt", 64'(hit_count), 64'd3);
        chk("t4_sdrop", 64'(slc_drop_cnt), 64'd2);
        chk("t4_roi_once", 64'(roi_n - r0), 64'd1);
        chk_writes("t4_wr", base, 4, 3);

        // 5: zero-hit candidate
        tick();
        base = wq.size(); r0 = roi_n;
        send_slc(64'h5);
        hit_in_last = 1'b1;
        tick();
        hit_in_last = 1'b0;
        wait_vld("t5_vld_seen");
        chk("t5_hcnt", 64'(hit_count), 64'd0);
        chk("t5_roi_once", 64'(roi_n - r0), 64'd1);
        chk("t5_no_wr", 64'(wq.size() - base), 64'd0);

        // 6: async reset in the middle of a stalled drain
        tick();
        mdt_hit_af = 1'b1;
        send_slc(64'h6);
        for (int i = 1; i <= 4; i++) send_hit(hv(6, i), i == 4);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_mdt_we", 64'(mdt_hit_we), 64'd0);
        chk("t6_hcnt", 64'(hit_count), 64'd0);
        chk("t6_sdrop", 64'(slc_drop_cnt), 64'd0);
        chk("t6_hdrop", 64'(hit_drop_cnt), 64'd0);
        tick();
        reset = 1'b0;
        mdt_hit_af = 1'b0;
        base = wq.size();
        tick(); tick(); tick();
        chk("t6_flushed", 64'(wq.size() - base), 64'd0);
        send_slc(64'h66);
        send_hit(hv(7, 1), 1'b0);
        send_hit(hv(7, 2), 1'b1);
        wait_vld("t6_vld_seen");
        chk("t6_hcnt_new", 64'(hit_count), 64'd2);
        chk_writes("t6_wr", base, 7, 2);
        chk("order", 64'(early_n), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
